// File: rtl/bus_pin_sequencer_if.sv
// Request/response and shared-pin bundle for bus_pin_sequencer.
// master = CPU/pad side, slave = sequencer.
interface bus_pin_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4,
    parameter int PIN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [PIN_W-1:0]  pin_in;
    logic [PIN_W-1:0]  pin_out;
    logic [PIN_W-1:0]  pin_oe;
    logic [1:0]        pin_phase;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, pin_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  pin_out, pin_oe, pin_phase
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, pin_in,
        output req_ready, rsp_valid, rsp_rdata,
        output pin_out, pin_oe, pin_phase
    );
endinterface

// File: rtl/bus_pin_sequencer.sv
// Serialises CPU address/data onto narrow shared pins, MS beat first,
// with read wait-states and a one-cycle completion strobe.
module bus_pin_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4,
    parameter int PIN_W  = 4,
    parameter int WAIT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_pin_sequencer_if.slave bus
);
    localparam int A     = ADDR_W / PIN_W;
    localparam int D     = DATA_W / PIN_W;
    localparam int MAX_AD = (A > D) ? A : D;
    localparam int MAXC  = (MAX_AD > WAIT) ? MAX_AD : WAIT;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'((WAIT > 0) ? WAIT - 1 : 0);

    generate
        if ((ADDR_W % PIN_W) != 0 || (DATA_W % PIN_W) != 0 ||
            ADDR_W < PIN_W || DATA_W < PIN_W ||
            WAIT < 0 || WAIT > 15) begin : g_bad_params
            $error("bus_pin_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RWAIT,
        RDATA
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_nxt;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_valid_q;
    logic              accept;
    logic              done;

    assign accept = bus.req_valid && (state == IDLE);
    assign rd_nxt = (rd_sh << PIN_W) | DATA_W'(bus.pin_in);
    assign done   = ((state == WDATA) || (state == RDATA)) && (cnt == D_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) state_next = ADDR;
            end
            ADDR: begin
                if (cnt == A_LAST) begin
                    if (we_q)          state_next = WDATA;
                    else if (WAIT > 0) state_next = RWAIT;
                    else               state_next = RDATA;
                end
            end
            WDATA: begin
                if (cnt == D_LAST) state_next = IDLE;
            end
            RWAIT: begin
                if (cnt == W_LAST) state_next = RDATA;
            end
            RDATA: begin
                if (cnt == D_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter restarts on every state change and idles at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_sh     <= '0;
            wdata_sh    <= '0;
            rd_sh       <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= done;
            if (state_next != state) cnt <= '0;
            else if (state != IDLE)  cnt <= cnt + CNT_W'(1);

            if (accept) begin
                we_q     <= bus.req_we;
                addr_sh  <= bus.req_addr;
                wdata_sh <= bus.req_wdata;
            end

            if (state == ADDR)  addr_sh  <= addr_sh << PIN_W;
            if (state == WDATA) wdata_sh <= wdata_sh << PIN_W;

            if (state == RDATA) begin
                rd_sh <= rd_nxt;
                if (cnt == D_LAST) rsp_rdata_q <= rd_nxt;
            end
        end
    end

    always_comb begin
        bus.pin_out   = '0;
        bus.pin_oe    = '0;
        bus.pin_phase = 2'b00;
        unique case (state)
            ADDR: begin
                bus.pin_out   = addr_sh[ADDR_W-1 -: PIN_W];
                bus.pin_oe    = '1;
                bus.pin_phase = 2'b01;
            end
            WDATA: begin
                bus.pin_out   = wdata_sh[DATA_W-1 -: PIN_W];
                bus.pin_oe    = '1;
                bus.pin_phase = 2'b10;
            end
            RWAIT, RDATA: begin
                bus.pin_phase = 2'b11;
            end
            default: begin
                bus.pin_phase = 2'b00;
            end
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_pin_sequencer.sv
// Directed bench for bus_pin_sequencer: default widths plus a
// DATA_W=8 / WAIT=0 instance sharing clock and reset.
module tb_bus_pin_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bus_pin_sequencer_if #(.ADDR_W(12), .DATA_W(4), .PIN_W(4)) bus0 ();
    bus_pin_sequencer_if #(.ADDR_W(12), .DATA_W(8), .PIN_W(4)) bus1 ();

    bus_pin_sequencer #(
        .ADDR_W(12), .DATA_W(4), .PIN_W(4), .WAIT(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    bus_pin_sequencer #(
        .ADDR_W(12), .DATA_W(8), .PIN_W(4), .WAIT(0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pins(input string tag, input logic [1:0] ph,
                        input logic [3:0] oe, input logic [3:0] out,
                        input logic [31:0] eph, input logic [31:0] eoe,
                        input logic [31:0] eout);
        check({tag, ".ph"}, 32'(ph), eph);
        check({tag, ".oe"}, 32'(oe), eoe);
        check({tag, ".out"}, 32'(out), eout);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic p0(input string tag, input logic [31:0] eph,
                      input logic [31:0] eoe, input logic [31:0] eout);
        pins(tag, bus0.pin_phase, bus0.pin_oe, bus0.pin_out, eph, eoe, eout);
    endtask

    task automatic p1(input string tag, input logic [31:0] eph,
                      input logic [31:0] eoe, input logic [31:0] eout);
        pins(tag, bus1.pin_phase, bus1.pin_oe, bus1.pin_out, eph, eoe, eout);
    endtask

    initial begin
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.pin_in    = '0;
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        bus1.pin_in    = '0;

        // power-on reset
        tick;
        tick;
        p0("rst0", 0, 0, 0);
        check("rst0.vld", 32'(bus0.rsp_valid), 0);
        check("rst0.rd", 32'(bus0.rsp_rdata), 0);
        p1("rst1", 0, 0, 0);
        rst_n = 1'b1;
        tick;
        check("rst0.rdy", 32'(bus0.req_ready), 1);

        // write A5C / 3
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 12'hA5C;
        bus0.req_wdata = 4'h3;
        tick;
        bus0.req_valid = 1'b0;
        p0("wr.c1", 1, 'hF, 'hA);
        check("wr.c1.rdy", 32'(bus0.req_ready), 0);
        tick;
        p0("wr.c2", 1, 'hF, 'h5);
        tick;
        p0("wr.c3", 1, 'hF, 'hC);
        tick;
        p0("wr.c4", 2, 'hF, 'h3);
        check("wr.c4.vld", 32'(bus0.rsp_valid), 0);
        tick;
        p0("wr.c5", 0, 0, 0);
        check("wr.c5.vld", 32'(bus0.rsp_valid), 1);
        check("wr.c5.rdy", 32'(bus0.req_ready), 1);
        tick;
        check("wr.c6.vld", 32'(bus0.rsp_valid), 0);

        // read 123, pin_in 9 during RDATA
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 12'h123;
        tick;
        bus0.req_valid = 1'b0;
        p0("rd.c1", 1, 'hF, 'h1);
        tick;
        p0("rd.c2", 1, 'hF, 'h2);
        tick;
        p0("rd.c3", 1, 'hF, 'h3);
        tick;
        p0("rd.c4", 3, 0, 0);
        bus0.pin_in = 4'h5;
        tick;
        p0("rd.c5", 3, 0, 0);
        check("rd.c5.vld", 32'(bus0.rsp_valid), 0);
        bus0.pin_in = 4'h9;
        tick;
        check("rd.c6.vld", 32'(bus0.rsp_valid), 1);
        check("rd.c6.rd", 32'(bus0.rsp_rdata), 'h9);
        p0("rd.c6", 0, 0, 0);
        tick;
        check("rd.c7.vld", 32'(bus0.rsp_valid), 0);
        check("rd.c7.rd", 32'(bus0.rsp_rdata), 'h9);

        // back-to-back write then read with req_valid held
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 12'h111;
        bus0.req_wdata = 4'h7;
        tick;
        bus0.req_we   = 1'b0;
        bus0.req_addr = 12'h456;
        bus0.pin_in   = 4'h0;
        p0("bb.w1", 1, 'hF, 'h1);
        tick;
        tick;
        tick;
        p0("bb.w4", 2, 'hF, 'h7);
        check("bb.w4.rd", 32'(bus0.rsp_rdata), 'h9);
        tick;
        check("bb.w5.vld", 32'(bus0.rsp_valid), 1);
        check("bb.w5.rdy", 32'(bus0.req_ready), 1);
        check("bb.w5.rd", 32'(bus0.rsp_rdata), 'h9);
        tick;
        bus0.req_valid = 1'b0;
        p0("bb.r1", 1, 'hF, 'h4);
        check("bb.r1.rdy", 32'(bus0.req_ready), 0);
        tick;
        p0("bb.r2", 1, 'hF, 'h5);
        tick;
        p0("bb.r3", 1, 'hF, 'h6);
        tick;
        p0("bb.r4", 3, 0, 0);
        bus0.pin_in = 4'h6;
        tick;
        tick;
        check("bb.r6.vld", 32'(bus0.rsp_valid), 1);
        check("bb.r6.rd", 32'(bus0.rsp_rdata), 'h6);
        tick;

        // abort a write during address beat 2
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 12'hABC;
        bus0.req_wdata = 4'h5;
        tick;
        bus0.req_valid = 1'b0;
        p0("ab.c1", 1, 'hF, 'hA);
        tick;
        p0("ab.c2", 1, 'hF, 'hB);
        rst_n = 1'b0;
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 12'hFFF;
        tick;
        p0("ab.r1", 0, 0, 0);
        check("ab.r1.vld", 32'(bus0.rsp_valid), 0);
        check("ab.r1.rd", 32'(bus0.rsp_rdata), 0);
        tick;
        bus0.req_valid = 1'b0;
        rst_n = 1'b1;
        tick;
        check("ab.rel.rdy", 32'(bus0.req_ready), 1);
        for (int i = 0; i < 4; i++) begin
            check("ab.idle.vld", 32'(bus0.rsp_valid), 0);
            check("ab.idle.ph", 32'(bus0.pin_phase), 0);
            tick;
        end
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = 12'h321;
        bus0.req_wdata = 4'hE;
        tick;
        bus0.req_valid = 1'b0;
        p0("ab.n1", 1, 'hF, 'h3);
        tick;
        tick;
        tick;
        p0("ab.n4", 2, 'hF, 'hE);
        tick;
        check("ab.n5.vld", 32'(bus0.rsp_valid), 1);
        check("ab.n5.rd", 32'(bus0.rsp_rdata), 0);

        // DATA_W=8, WAIT=0 read of FFF
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = 12'hFFF;
        tick;
        bus1.req_valid = 1'b0;
        p1("w8.c1", 1, 'hF, 'hF);
        tick;
        p1("w8.c2", 1, 'hF, 'hF);
        tick;
        p1("w8.c3", 1, 'hF, 'hF);
        tick;
        p1("w8.c4", 3, 0, 0);
        bus1.pin_in = 4'h4;
        tick;
        p1("w8.c5", 3, 0, 0);
        check("w8.c5.vld", 32'(bus1.rsp_valid), 0);
        bus1.pin_in = 4'hE;
        tick;
        check("w8.c6.vld", 32'(bus1.rsp_valid), 1);
        check("w8.c6.rd", 32'(bus1.rsp_rdata), 'h4E);
        p1("w8.c6", 0, 0, 0);
        tick;
        check("w8.c7.vld", 32'(bus1.rsp_valid), 0);
        check("w8.c7.rd", 32'(bus1.rsp_rdata), 'h4E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
